// File: rtl/disp_pkg.sv
// disp_pkg: shared digit indices, scan FSM states and segment constants for the display scanner.
package disp_pkg;
    localparam logic [2:0] DIG_H    = 3'd7;
    localparam logic [2:0] DIG_MIN1 = 3'd6;
    localparam logic [2:0] DIG_MIN0 = 3'd5;
    localparam logic [2:0] DIG_S1   = 3'd4;
    localparam logic [2:0] DIG_S0   = 3'd3;
    localparam logic [2:0] DIG_MS2  = 3'd2;
    localparam logic [2:0] DIG_MS1  = 3'd1;
    localparam logic [2:0] DIG_MS0  = 3'd0;
    typedef enum logic [1:0] {ST_IDLE, ST_LATCH, ST_BLANK, ST_DRIVE} state_t;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [7:0] DP_MASK   = 8'b1010_1000;
endpackage

// File: rtl/disp_scan_ctrl_dec.sv
// bcd7seg_dec: BCD digit to active-low seven-segment pattern (g..a), dash for invalid codes.
module bcd7seg_dec
    import disp_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg_n
);
    always_comb begin
        case (i_bcd)
            4'd0:    o_seg_n = 7'h40;
            4'd1:    o_seg_n = 7'h79;
            4'd2:    o_seg_n = 7'h24;
            4'd3:    o_seg_n = 7'h30;
            4'd4:    o_seg_n = 7'h19;
            4'd5:    o_seg_n = 7'h12;
            4'd6:    o_seg_n = 7'h02;
            4'd7:    o_seg_n = 7'h78;
            4'd8:    o_seg_n = 7'h00;
            4'd9:    o_seg_n = 7'h10;
            default: o_seg_n = SEG_DASH;
        endcase
    end
endmodule

// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl: 8-digit multiplexed seven-segment scanner with per-frame snapshot and blanking gap.
// Optional leading-zero blanking of digits 7..4 when DISP_LZB_EN is defined.
module disp_scan_ctrl
    import disp_pkg::*;
#(
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 16
)(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       freeze,
    input  logic [3:0] bcd_h,
    input  logic [3:0] bcd_min_1,
    input  logic [3:0] bcd_min_0,
    input  logic [3:0] bcd_s_1,
    input  logic [3:0] bcd_s_0,
    input  logic [3:0] bcd_ms_2,
    input  logic [3:0] bcd_ms_1,
    input  logic [3:0] bcd_ms_0,
    output logic [6:0] seg_n,
    output logic       dp_n,
    output logic [7:0] an_n,
    output logic       frame_start
);
    localparam int CW = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
    localparam logic [CW-1:0] DRIVE_LAST = CW'(SCAN_DIV - BLANK_CYC - 1);

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [2:0]      r_idx;
    logic [7:0][3:0] r_snap;
    logic            r_en_q;

    logic [7:0][3:0] w_live;
    logic [7:0][3:0] w_snap_nx;
    logic [2:0]      w_idx_nx;
    logic [6:0]      w_seg_dec;
    logic [6:0]      w_seg_nx;
    logic            w_last;

    assign w_live    = {bcd_h, bcd_min_1, bcd_min_0, bcd_s_1, bcd_s_0, bcd_ms_2, bcd_ms_1, bcd_ms_0};
    // The first blank slot must already show the freshly latched digit, so decode the incoming snapshot.
    assign w_snap_nx = (r_state == ST_LATCH && !freeze) ? w_live : r_snap;
    assign w_idx_nx  = (r_state == ST_LATCH) ? DIG_H : r_idx - 3'd1;
    assign w_last    = r_cnt == ((r_state == ST_BLANK) ? BLANK_LAST : DRIVE_LAST);

    bcd7seg_dec u_dec (
        .i_bcd   (w_snap_nx[w_idx_nx]),
        .o_seg_n (w_seg_dec)
    );

`ifdef DISP_LZB_EN
    logic [7:0] w_lz;
    always_comb begin
        w_lz      = '0;
        w_lz[7]   = w_snap_nx[7] == 4'd0;
        w_lz[6]   = w_lz[7] && w_snap_nx[6] == 4'd0;
        w_lz[5]   = w_lz[6] && w_snap_nx[5] == 4'd0;
        w_lz[4]   = w_lz[5] && w_snap_nx[4] == 4'd0;
    end
    assign w_seg_nx = w_lz[w_idx_nx] ? SEG_BLANK : w_seg_dec;
`else
    assign w_seg_nx = w_seg_dec;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_idx       <= DIG_H;
            r_snap      <= '0;
            r_en_q      <= 1'b0;
            seg_n       <= SEG_BLANK;
            dp_n        <= 1'b1;
            an_n        <= 8'hFF;
            frame_start <= 1'b0;
        end else if (!en) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_en_q      <= 1'b0;
            seg_n       <= SEG_BLANK;
            dp_n        <= 1'b1;
            an_n        <= 8'hFF;
            frame_start <= 1'b0;
        end else begin
            r_en_q      <= 1'b1;
            r_cnt       <= r_cnt + 1'b1;
            frame_start <= 1'b0;
            case (r_state)
                ST_IDLE: if (r_en_q) begin
                    r_state     <= ST_LATCH;
                    r_cnt       <= '0;
                    frame_start <= 1'b1;
                end
                ST_LATCH: begin
                    r_state <= ST_BLANK;
                    r_cnt   <= '0;
                    r_snap  <= w_snap_nx;
                    r_idx   <= w_idx_nx;
                    seg_n   <= w_seg_nx;
                    dp_n    <= ~DP_MASK[w_idx_nx];
                    an_n    <= 8'hFF;
                end
                ST_BLANK: if (w_last) begin
                    r_state <= ST_DRIVE;
                    r_cnt   <= '0;
                    an_n    <= ~(8'b1 << r_idx);
                end
                ST_DRIVE: if (w_last) begin
                    r_cnt <= '0;
                    an_n  <= 8'hFF;
                    if (r_idx == DIG_MS0) begin
                        r_state     <= ST_LATCH;
                        frame_start <= 1'b1;
                        seg_n       <= SEG_BLANK;
                        dp_n        <= 1'b1;
                    end else begin
                        r_state <= ST_BLANK;
                        r_idx   <= w_idx_nx;
                        seg_n   <= w_seg_nx;
                        dp_n    <= ~DP_MASK[w_idx_nx];
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_disp_scan_ctrl.sv
// tb_disp_scan_ctrl: directed bench for disp_scan_ctrl with a frame-position model checked every cycle.
module tb_disp_scan_ctrl;
    localparam int SD = 8;
    localparam int BC = 2;
    localparam int FL = 1 + 8 * SD;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       freeze = 1'b0;
    logic [3:0] d [8];
    logic [6:0] seg_n;
    logic       dp_n;
    logic [7:0] an_n;
    logic       frame_start;

    int total = 0;
    int bad = 0;
    bit started = 1'b0;

    logic [6:0] tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
    logic [7:0] dpm = 8'hA8;
    logic [7:0] an_e [8] = '{8'h7F, 8'hBF, 8'hDF, 8'hEF, 8'hF7, 8'hFB, 8'hFD, 8'hFE};
    logic [7:0] seg_e [8] = '{8'h79, 8'h24, 8'h30, 8'h19, 8'h12, 8'h02, 8'h78, 8'h00};
`ifdef DISP_LZB_EN
    logic [7:0] lz_h_e = 8'h7F;
`else
    logic [7:0] lz_h_e = 8'h40;
`endif

    disp_scan_ctrl #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .freeze      (freeze),
        .bcd_h       (d[7]),
        .bcd_min_1   (d[6]),
        .bcd_min_0   (d[5]),
        .bcd_s_1     (d[4]),
        .bcd_s_0     (d[3]),
        .bcd_ms_2    (d[2]),
        .bcd_ms_1    (d[1]),
        .bcd_ms_0    (d[0]),
        .seg_n       (seg_n),
        .dp_n        (dp_n),
        .an_n        (an_n),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: m_pos counts cycles since the snapshot cycle of the current frame.
    bit         m_act = 1'b0;
    bit         m_pen = 1'b0;
    int         m_pos = 0;
    logic [3:0] m_snap [8] = '{default: 4'd0};

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_act  <= 1'b0;
            m_pen  <= 1'b0;
            m_pos  <= 0;
            m_snap <= '{default: 4'd0};
        end else if (!en) begin
            m_act <= 1'b0;
            m_pen <= 1'b0;
        end else if (!m_act) begin
            if (m_pen) begin
                m_act <= 1'b1;
                m_pos <= 0;
            end
            m_pen <= 1'b1;
        end else begin
            if (m_pos == 0 && !freeze) m_snap <= d;
            m_pos <= (m_pos == FL - 1) ? 0 : m_pos + 1;
        end
    end

    function automatic logic [6:0] m_seg(input int idx);
`ifdef DISP_LZB_EN
        bit z = 1'b1;
        if (idx >= 4) begin
            for (int j = 7; j >= idx; j--) z &= (m_snap[j] == 4'd0);
            if (z) return 7'h7F;
        end
`endif
        return tab[m_snap[idx]];
    endfunction

    always @(negedge clk) begin
        if (started) begin
            logic [7:0] e_an;
            logic [6:0] e_seg;
            logic       e_dp, e_fs;
            int         k, idx;
            e_an = 8'hFF; e_seg = 7'h7F; e_dp = 1'b1; e_fs = 1'b0;
            if (m_act) begin
                if (m_pos == 0) e_fs = 1'b1;
                else begin
                    k     = (m_pos - 1) / SD;
                    idx   = 7 - k;
                    e_seg = m_seg(idx);
                    e_dp  = !dpm[idx];
                    if ((m_pos - 1) % SD >= BC) e_an = ~(8'b1 << idx);
                end
            end
            chk("mdl_seg", {1'b0, seg_n}, {1'b0, e_seg});
            chk("mdl_dp", {7'b0, dp_n}, {7'b0, e_dp});
            chk("mdl_an", an_n, e_an);
            chk("mdl_fs", {7'b0, frame_start}, {7'b0, e_fs});
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_fs(input string nm);
        int i = 0;
        while (frame_start !== 1'b1 && i < 200) begin
            @(negedge clk);
            i++;
        end
        total++;
        if (frame_start !== 1'b1) begin
            bad++;
            $display("FAIL %s: frame_start=%b after %0d cycles want 1", nm, frame_start, i);
        end
    endtask

    initial begin
        d[7] = 4'd1; d[6] = 4'd2; d[5] = 4'd3; d[4] = 4'd4;
        d[3] = 4'd5; d[2] = 4'd6; d[1] = 4'd7; d[0] = 4'd8;
        step(3);
        started = 1'b1;
        chk("rst_seg", {1'b0, seg_n}, 8'h7F);
        chk("rst_dp", {7'b0, dp_n}, 8'h01);
        chk("rst_an", an_n, 8'hFF);
        chk("rst_fs", {7'b0, frame_start}, 8'h00);
        rst_n = 1'b1;
        step(2);
        en = 1'b1;
        wait_fs("first_fs");
        step(1);
        chk("blank_an", an_n, 8'hFF);
        chk("blank_seg", {1'b0, seg_n}, 8'h79);
        chk("blank_dp", {7'b0, dp_n}, 8'h00);
        for (int k = 0; k < 8; k++) begin
            step(k == 0 ? 2 : 8);
            chk("scan_an", an_n, an_e[k]);
            chk("scan_seg", {1'b0, seg_n}, seg_e[k]);
        end
        step(6);
        chk("period", {7'b0, frame_start}, 8'h01);
        step(10);
        d[3] = 4'd9;
        step(25);
        chk("midframe_hold", {1'b0, seg_n}, 8'h12);
        step(FL);
        chk("next_frame", {1'b0, seg_n}, 8'h10);
        freeze = 1'b1;
        d[7] = 4'd3;
        step(FL - 35 + 3);
        chk("freeze_hold", {1'b0, seg_n}, 8'h79);
        freeze = 1'b0;
        step(FL);
        chk("unfreeze", {1'b0, seg_n}, 8'h30);
        d[1] = 4'hC;
        step(FL + 48);
        chk("dash_seg", {1'b0, seg_n}, 8'h3F);
        chk("dash_an", an_n, 8'hFD);
        en = 1'b0;
        step(1);
        chk("endrop_an", an_n, 8'hFF);
        chk("endrop_seg", {1'b0, seg_n}, 8'h7F);
        d[7] = 4'd0; d[6] = 4'd0; d[5] = 4'd5;
        en = 1'b1;
        wait_fs("re_fs");
        step(1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_an", an_n, 8'hFF);
        chk("arst_seg", {1'b0, seg_n}, 8'h7F);
        chk("arst_dp", {7'b0, dp_n}, 8'h01);
        step(1);
        rst_n = 1'b1;
        wait_fs("restart_fs");
        step(3);
        chk("lzb_h", {1'b0, seg_n}, lz_h_e);
        step(16);
        chk("lzb_min0_seg", {1'b0, seg_n}, 8'h12);
        chk("lzb_min0_dp", {7'b0, dp_n}, 8'h00);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/disp_scan_ctrl.md
# disp_scan_ctrl

Time-multiplexing controller for the stopwatch's 8-digit common-anode seven-segment display. It takes the eight BCD digits produced by the binary-to-BCD stage (hours, minutes, seconds, milliseconds) and snapshots them once per frame. It then scans the digits one at a time onto a shared segment bus, inserting a blanking gap between digits to prevent ghosting. It sits between the BCD conversion stage and the board's display pins.

## Interface
- SCAN_DIV, 50000: clock cycles per digit slot (blank + drive); legal range BLANK_CYC+2 .. 2^20.
- BLANK_CYC, 16: cycles per slot with all anodes off; must be ≥1.
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- en  in  1  scan enable; low forces display dark.
- freeze  in  1  lap hold; when high at snapshot time, the previous snapshot is kept.
- bcd_h  in  4  hours digit.
- bcd_min_1, bcd_min_0  in  4 each  minutes tens/units.
- bcd_s_1, bcd_s_0  in  4 each  seconds tens/units.
- bcd_ms_2, bcd_ms_1, bcd_ms_0  in  4 each  milliseconds hundreds/tens/units.
- seg_n  out  7  segments g..a, active-low (bit0 = a).
- dp_n  out  1  decimal point, active-low.
- an_n  out  8  digit anodes, active-low; index 7 = hours, 0 = ms units.
- frame_start  out  1  one-cycle pulse in the snapshot cycle.

## Operation
- Digit map: idx7 = h, 6 = min_1, 5 = min_0, 4 = s_1, 3 = s_0, 2 = ms_2, 1 = ms_1, 0 = ms_0.
- FSM states: IDLE, LATCH, BLANK, DRIVE.
- IDLE: outputs dark (seg_n = 7F, dp_n = 1, an_n = FF). If en=1, go to LATCH.
- LATCH: one cycle; frame_start = 1. If freeze=0, capture all 8 inputs into the snapshot; otherwise keep the old snapshot. Set digit idx = 7 and go to BLANK.
- BLANK: lasts BLANK_CYC cycles. an_n = FF. seg_n/dp_n carry the current idx's pattern so segments settle before the anode turns on. Then go to DRIVE.
- DRIVE: lasts SCAN_DIV−BLANK_CYC cycles. an_n[idx] = 0, all other anodes = 1. At the end, if idx = 0 go to LATCH; else decrement idx and go to BLANK.
- en=0 in any state: go to IDLE on the next edge, with dark outputs on that edge.
- Decode:
  - Values 0–9 use standard patterns, e.g. 0 → seg_n 7'h40 and 8 → 7'h00.
  - Values 10–15 (invalid BCD) show "-" (g only, seg_n = 7'h3F).
- dp_n = 0 at idx 7, 5 and 3 (separators after h, min and s); 1 elsewhere.
- Slot counter width is $clog2(SCAN_DIV); it resets to 0 on every state entry.

## Timing
- Reset values: seg_n = 7F, dp_n = 1, an_n = FF, frame_start = 0. State = IDLE, snapshot = all zero, idx = 7.
- All outputs are registered; no combinational path from inputs to outputs.
- en rising seen at edge N: LATCH is active after edge N+1, with frame_start = 1 during that cycle.
- First anode is low BLANK_CYC+1 cycles after LATCH.
- Frame period = 1 + 8·SCAN_DIV cycles; frames repeat back-to-back while en = 1.
- Inputs are sampled only in the LATCH cycle; changes mid-frame never appear until the next frame.
- At most one anode is ever low. There is never an overlap between anode changes and segment changes.
- Asynchronous reset mid-frame: outputs go dark immediately. After release, the controller restarts from IDLE.

## Configuration
- DISP_LZB_EN: leading-zero blanking.
  - Defined: in the snapshot, digits idx7 down to idx4 that are 0 and have only zeros to their left are blanked (seg_n = 7F, dp_n still per rule). idx 3 and below always display.
  - Undefined: all digits are displayed, including leading zeros.

## Structure
- Shared package disp_pkg holds:
  - the digit index constants (DIG_H = 7 … DIG_MS0 = 0);
  - the state enum;
  - the segment constants SEG_BLANK = 7'h7F and SEG_DASH = 7'h3F;
  - the DP mask 8'b1010_1000.
- One sub-module, bcd7seg_dec: combinational 4-bit BCD to active-low 7-segment decoder, including the dash for invalid values. It is instantiated once on the muxed snapshot digit.

## Test plan
- Apply reset with SCAN_DIV=8, BLANK_CYC=2, inputs h=1, min=23, s=45, ms=678, then en=1 → frame_start every 65 cycles. an_n steps 7F, BF, … FE, each low for 6 cycles after 2 dark cycles. seg_n sequence 79, 24, 30, 19, 12, 02, 78, 00.
- Change bcd_s_0 mid-frame → the displayed value changes only after the next frame_start.
- Set freeze=1 before LATCH while inputs change → the next frame shows the old snapshot. Clear freeze → the following frame shows the new values.
- Set bcd_ms_1 = 4'hC → seg_n = 3F in the idx1 slot.
- Drop en during DRIVE → the next cycle has an_n = FF and seg_n = 7F. Assert rst_n low mid-BLANK → immediate reset values.
- With DISP_LZB_EN, h=0, min=05 → idx7 and idx6 are blank, idx5 shows "5" with dp_n = 0. Without the macro, they show "0".
